pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 124 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready.
// Optional downstream-stall counter enabled by macro PIPE_SKID_REG_STALL_CNT_EN;
// without it stall_cnt is tied to zero and no counter flops exist.
module pipe_skid_reg #(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(32'h0000_0013)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [31:0]      stall_cnt
);

   localparam int unsigned CNT_W = 32;

   // State encoding doubles as the occupancy count
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             xfer_in, xfer_out;

   // State and payload registers; reset empties the block immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= BUBBLE_VAL;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state: flush wins, then fill/drain of main and skid entries
   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      xfer_in  = in_valid && in_ready_q;
      xfer_out = out_valid_q && out_ready;

      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (xfer_in) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (xfer_in && xfer_out) begin
                  main_d = in_data;
               end else if (xfer_out) begin
                  main_d  = BUBBLE_VAL;
                  state_d = ST_EMPTY;
               end else if (xfer_in) begin
                  skid_d  = in_data;
                  state_d = ST_TWO;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a drain can happen
               if (xfer_out) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE_VAL;
            end
         endcase
      end

      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_TWO);
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

`ifdef PIPE_SKID_REG_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   // Count edges where a valid head is held back; flush does not clear it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid_q && !out_ready) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;

   localparam logic [31:0] BUBBLE = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] q[$];
   logic [31:0] m_stall = 32'd0;

   pipe_skid_reg dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // Compare every output against the model's view of the held words
   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      check({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
      check({tag, ".out_data"},  out_data, (sz > 0) ? q[0] : BUBBLE);
      check({tag, ".in_ready"},  32'(in_ready), 32'(sz < 2));
      check({tag, ".occupancy"}, 32'(occupancy), 32'(sz));
      check({tag, ".stall_cnt"}, stall_cnt, m_stall);
   endtask

   // Apply inputs for one edge, advance the model, then sample
   task automatic step(input string tag, input logic iv, input logic [31:0] id,
                       input logic ordy, input logic fl);
      int sz;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      sz = q.size();
`ifdef PIPE_SKID_REG_STALL_CNT_EN
      if (sz > 0 && !ordy) m_stall = m_stall + 32'd1;
`endif
      if (fl) begin
         q.delete();
      end else begin
         if (ordy && sz > 0) void'(q.pop_front());
         if (iv && sz < 2) q.push_back(id);
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Streaming at full rate
      step("stream0", 1'b1, 32'h11, 1'b1, 1'b0);
      step("stream1", 1'b1, 32'h22, 1'b1, 1'b0);
      step("stream2", 1'b1, 32'h33, 1'b1, 1'b0);
      step("stream3", 1'b0, 32'h0,  1'b1, 1'b0);

      // Backpressure fills skid, then drain
      step("bp_a1",  1'b1, 32'hA1, 1'b0, 1'b0);
      step("bp_a2",  1'b1, 32'hA2, 1'b0, 1'b0);
      step("bp_hold",1'b1, 32'hA3, 1'b0, 1'b0);
      step("bp_d1",  1'b0, 32'h0,  1'b1, 1'b0);
      step("bp_d2",  1'b0, 32'h0,  1'b1, 1'b0);

      // Flush at occupancy 2 drops the concurrent word
      step("fl_f1",  1'b1, 32'hC1, 1'b0, 1'b0);
      step("fl_f2",  1'b1, 32'hC2, 1'b0, 1'b0);
      step("flush",  1'b1, 32'hBEEF, 1'b0, 1'b1);
      step("fl_after",1'b0, 32'h0, 1'b1, 1'b0);

      // Simultaneous in/out at occupancy 1
      step("sim_5",  1'b1, 32'h5, 1'b0, 1'b0);
      step("sim_6",  1'b1, 32'h6, 1'b1, 1'b0);
      step("sim_end",1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges at occupancy 2
      step("ar_1",   1'b1, 32'hD1, 1'b0, 1'b0);
      step("ar_2",   1'b1, 32'hD2, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      m_stall = 32'd0;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("ar_77",  1'b1, 32'h77, 1'b1, 1'b0);
      step("ar_end", 1'b0, 32'h0,  1'b1, 1'b0);

      // Stall counting, survives flush
      step("st_load",1'b1, 32'h99, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("st_hold", 1'b0, 32'h0, 1'b0, 1'b0);
      step("st_flush",1'b0, 32'h0, 1'b1, 1'b1);
      step("st_idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'($urandom_range(0, 1)),
              $urandom,
              1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
